// File: rtl/spi_pkg.sv
// spi_pkg: frame geometry, FSM state type and opcodes shared with the SPI receive stage
package spi_pkg;
  localparam int OPC_W   = 8;
  localparam int DATA_W  = 80;
  localparam int FRAME_W = OPC_W + DATA_W;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
  localparam logic [OPC_W-1:0] OPC_NOP   = 8'h00;
  localparam logic [OPC_W-1:0] OPC_WRITE = 8'hA5;
  localparam logic [OPC_W-1:0] OPC_READ  = 8'h5A;
  localparam logic [OPC_W-1:0] OPC_CFG   = 8'hC3;
  localparam logic [OPC_W-1:0] OPC_RESET = 8'hFF;
endpackage

// File: rtl/spi_down_cnt.sv
// spi_down_cnt: loadable down-counter shared by the bit and gap phases
module spi_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk_spi,
  input  logic         rstb,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over decrement; hold otherwise
  always_comb cnt_d = load_i ? val_i : dec_i ? cnt_q - W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk_spi or negedge rstb)
    if (!rstb) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI master frame serializer, cs low for FRAME_W cycles then a guaranteed cs-high gap
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int GAP_CYCLES = 7,
  parameter int CNT_W      = 16
) (
  input  logic              clk_spi,
  input  logic              rstb,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [OPC_W-1:0]  tx_opcode,
  input  logic [DATA_W-1:0] tx_data,
  output logic              cs,
  output logic              spi_mosi,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frames_sent
);
  localparam int CW = 8;
  state_e state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val;

  spi_down_cnt #(.W(CW)) u_cnt (
    .clk_spi(clk_spi),
    .rstb(rstb),
    .load_i(cnt_load),
    .dec_i(cnt_dec),
    .val_i(cnt_val),
    .zero_o(cnt_zero)
  );

  // state register
  always_ff @(posedge clk_spi or negedge rstb)
    if (!rstb) state_q <= IDLE;
    else state_q <= state_d;

  // next state: accept in IDLE, leave SHIFT/GAP when the shared counter expires
  always_comb
    state_d = state_q == IDLE  ? (tx_valid ? SHIFT : IDLE) :
              state_q == SHIFT ? (cnt_zero ? GAP : SHIFT) :
                                 (cnt_zero ? IDLE : GAP);

  // datapath and registered-output next values
  always_comb begin
    shift_d  = shift_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    frames_d = frames_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = CW'(FRAME_W - 1);
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: if (tx_valid) begin
        shift_d  = {tx_opcode, tx_data};
        cs_d     = 1'b0;
        mosi_d   = tx_opcode[OPC_W-1];
        cnt_load = 1'b1;
      end
      SHIFT: if (!cnt_zero) begin
        shift_d = shift_q << 1;
        mosi_d  = shift_q[FRAME_W-2];
        cnt_dec = 1'b1;
      end else begin
        cs_d     = 1'b1;
        mosi_d   = 1'b0;
        done_d   = 1'b1;
        frames_d = frames_q + CNT_W'(1);
        cnt_load = 1'b1;
        cnt_val  = CW'(GAP_CYCLES - 1);
      end
      default: cnt_dec = !cnt_zero;
    endcase
  end

  // datapath and output registers; reset forces cs high immediately, abandoning any frame
  always_ff @(posedge clk_spi or negedge rstb)
    if (!rstb) begin
      shift_q  <= '0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      shift_q  <= shift_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      frames_q <= frames_d;
    end

  assign tx_ready    = (state_q == IDLE);
  assign cs          = cs_q;
  assign spi_mosi    = mosi_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frames_sent = frames_q;
endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: directed self-checking bench for spi_frame_tx
module tb_spi_frame_tx;
  logic clk_spi = 0, rstb = 0, tx_valid = 0, rstb_w = 0;
  logic [7:0] tx_opcode = 0;
  logic [79:0] tx_data = 0;
  logic tx_ready, cs, spi_mosi, busy, frame_done;
  logic [15:0] frames_sent;
  logic rdy_w, cs_w, mosi_w, busy_w, fd_w;
  logic [3:0] fs_w;
  int checks = 0, errors = 0, exp_frames = 0;

  spi_frame_tx dut (
    .clk_spi(clk_spi), .rstb(rstb), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_opcode(tx_opcode), .tx_data(tx_data), .cs(cs), .spi_mosi(spi_mosi),
    .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  spi_frame_tx #(.GAP_CYCLES(1), .CNT_W(4)) u_w (
    .clk_spi(clk_spi), .rstb(rstb_w), .tx_valid(1'b1), .tx_ready(rdy_w),
    .tx_opcode(8'h5A), .tx_data(80'h1), .cs(cs_w), .spi_mosi(mosi_w),
    .busy(busy_w), .frame_done(fd_w), .frames_sent(fs_w)
  );

  always #5 clk_spi = ~clk_spi;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk_spi);
    chk("ready_wait", tx_ready, 1);
  endtask

  task automatic send(input string tag, input logic [7:0] opc, input logic [79:0] dat, input bit scramble);
    logic [87:0] word = 0;
    int lows = 0, first = -1, last = -1, dones = 0, didx = -1;
    wait_ready();
    @(negedge clk_spi);
    tx_valid = 1; tx_opcode = opc; tx_data = dat;
    @(posedge clk_spi);
    #1 tx_valid = 0;
    if (scramble) begin tx_opcode = ~opc; tx_data = ~dat; end
    chk({tag, "_busy_acc"}, busy, 1);
    chk({tag, "_ready_acc"}, tx_ready, 0);
    for (int i = 0; i < 96; i++) begin
      @(negedge clk_spi);
      if (!cs) begin
        word = {word[86:0], spi_mosi};
        lows++;
        if (first < 0) first = i;
        last = i;
      end
      if (frame_done) begin dones++; didx = i; end
      if (i == 94) begin chk({tag, "_ready_gap"}, tx_ready, 0); chk({tag, "_busy_gap"}, busy, 1); end
      if (i == 95) begin chk({tag, "_ready_end"}, tx_ready, 1); chk({tag, "_busy_end"}, busy, 0); end
    end
    exp_frames++;
    chk({tag, "_word"}, word, {opc, dat});
    chk({tag, "_cs_low"}, lows, 88);
    chk({tag, "_first"}, first, 0);
    chk({tag, "_last"}, last, 87);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_done_idx"}, didx, 88);
    chk({tag, "_frames"}, frames_sent, exp_frames);
  endtask

  initial begin
    int falls[4];
    int gaps[4];
    int nf, hrun, dn, nd;
    logic prev_cs;
    tx_valid = 1; tx_opcode = 8'hA5;
    repeat (4) @(negedge clk_spi);
    chk("rst_cs", cs, 1);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_frames", frames_sent, 0);
    tx_valid = 0; rstb = 1;
    repeat (3) @(negedge clk_spi);
    chk("idle_cs", cs, 1);

    send("f1", 8'hA5, 80'h0123_4567_89AB_CDEF_F00D, 0);
    send("scr", 8'h3C, 80'hFFFF_0000_AAAA_5555_1234, 1);

    wait_ready();
    @(negedge clk_spi);
    tx_valid = 1; tx_opcode = 8'h5A; tx_data = 80'h1;
    nf = 0; hrun = 0; dn = 0; prev_cs = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_spi);
      if (!cs && prev_cs && nf < 4) begin
        if (nf > 0) gaps[nf-1] = hrun;
        falls[nf] = i;
        nf++;
        hrun = 0;
      end
      if (cs) hrun++;
      if (frame_done) dn++;
      prev_cs = cs;
      if (i == 192) tx_valid = 0;
    end
    exp_frames += 3;
    chk("b2b_nframes", nf, 3);
    chk("b2b_fall0", falls[0], 0);
    chk("b2b_period1", falls[1] - falls[0], 96);
    chk("b2b_period2", falls[2] - falls[1], 96);
    chk("b2b_gap1", gaps[0], 8);
    chk("b2b_gap2", gaps[1], 8);
    chk("b2b_dones", dn, 3);
    chk("b2b_frames", frames_sent, exp_frames);

    wait_ready();
    @(negedge clk_spi);
    tx_valid = 1; tx_opcode = 8'hFF; tx_data = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    @(posedge clk_spi);
    #1 tx_valid = 0;
    repeat (40) @(negedge clk_spi);
    chk("mid_cs_before", cs, 0);
    rstb = 0;
    #1;
    chk("mid_cs", cs, 1);
    chk("mid_mosi", spi_mosi, 0);
    chk("mid_ready", tx_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_frames", frames_sent, 0);
    exp_frames = 0;
    @(negedge clk_spi);
    rstb = 1;
    send("post", 8'hC3, 80'hDEAD_BEEF_0000_1111_2222, 0);

    @(negedge clk_spi);
    rstb_w = 1;
    nd = 0;
    for (int i = 0; i < 2000 && nd < 17; i++) begin
      @(negedge clk_spi);
      if (fd_w) begin
        nd++;
        if (nd == 15) chk("wrap15", fs_w, 15);
        if (nd == 16) chk("wrap16", fs_w, 0);
      end
    end
    chk("wrap_count", nd, 17);
    chk("wrap17", fs_w, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Master-side SPI frame serializer, clocked on clk_spi; the stage directly upstream of the SPI receive stage.
- Accepts one command (8-bit opcode + 80-bit packed data) through a valid/ready handshake.
- Drives cs low for exactly FRAME_W clk_spi cycles and shifts the frame out MSB-first on spi_mosi.
- Then holds cs high for a guaranteed gap, so the receive stage's clk_sys-domain cs synchronizer sees every rising edge.

Parameters:
- OPC_W, 8, opcode width.
- DATA_W, 80, packed data width.
- FRAME_W, OPC_W+DATA_W (88), bits per frame; derived, not overridden.
- GAP_CYCLES, 7, idle cycles after a frame before a new frame may be accepted; legal range 1..255.
- CNT_W, 16, width of frames_sent counter.

Ports:
- clk_spi, input, 1, SPI bit clock; all logic on posedge.
- rstb, input, 1, asynchronous active-low reset.
- tx_valid, input, 1, command present.
- tx_ready, output, 1, block can accept a command; high only in IDLE.
- tx_opcode, input, OPC_W, opcode; sent first, MSB first.
- tx_data, input, DATA_W, payload; sent after opcode, bit DATA_W-1 first.
- cs, output, 1, chip select, active low, registered.
- spi_mosi, output, 1, serial data, registered.
- busy, output, 1, high in SHIFT or GAP.
- frame_done, output, 1, one-cycle pulse when cs returns high after a complete frame.
- frames_sent, output, CNT_W, count of completed frames; wraps.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE, cs=1, spi_mosi=0, frame_done=0, frames_sent=0, shift register and counters 0. Outputs therefore read tx_ready=1, busy=0.
- States:
  - IDLE: tx_ready=1. On a posedge with tx_valid=1:
    - load shift register {tx_opcode, tx_data};
    - cs<=0, spi_mosi<=tx_opcode[OPC_W-1];
    - bit_cnt<=FRAME_W-1;
    - go to SHIFT.
  - IDLE with tx_valid=0: hold. tx_valid is ignored in every other state; inputs are sampled only on the accept edge.
  - SHIFT, bit_cnt!=0: shift left, spi_mosi<=next bit, bit_cnt--.
  - SHIFT, bit_cnt==0: cs<=1, spi_mosi<=0, frame_done<=1, frames_sent++, gap_cnt<=GAP_CYCLES-1, go to GAP.
  - GAP: frame_done<=0. If gap_cnt==0 go to IDLE, else gap_cnt--.
- Timing, with accept at edge A:
  - cs is low after edges A..A+87, so exactly FRAME_W cycles.
  - Bit k (k=0 is the frame MSB) is driven after edge A+k and is stable for the receiver's posedge sample at A+k+1.
  - cs is high after edge A+88; frame_done is high for the cycle after A+88.
  - tx_ready is high after edge A+88+GAP_CYCLES. The earliest next accept is edge A+89+GAP_CYCLES, so cs is high for at least GAP_CYCLES+1 cycles.
- Back-to-back: tx_valid held high gives a frame period of FRAME_W+GAP_CYCLES+1 cycles (96 at defaults).
- frames_sent wraps from 2^CNT_W-1 to 0 without a stall.
- Reset mid-frame: cs rises immediately and the frame is abandoned. The receiver will flag a truncated frame as valid; system software must reset both sides together. This is a documented limitation.
- tx_ready is a combinational decode of state; every other output is a register.

Decomposition:
- Package spi_pkg:
  - OPC_W, DATA_W, FRAME_W constants;
  - state enum {IDLE, SHIFT, GAP};
  - opcode constant list shared with the receive stage.
- No sub-module required. The bit/gap down-counter is an optional sub-module, spi_down_cnt.

Test Plan:
- Reset with tx_valid=1 and rstb low → cs=1, spi_mosi=0, tx_ready=1, frames_sent=0; no frame starts until rstb rises.
- opcode=0xA5, data=80'h0123_4567_89AB_CDEF_F00D → capture mosi on 88 posedges while cs=0; reassembled word equals {A5, data}; cs low exactly 88 cycles; frame_done one pulse.
- tx_valid held high for 3 frames → cs high gaps are exactly 8 cycles each; frames_sent=3; frame period 96 cycles.
- tx_data changed while busy → transmitted frame matches the value on the accept edge.
- rstb pulsed at bit 40 → cs=1 asynchronously, state IDLE; the next frame transmits correctly.
- Preload frames_sent near wrap (CNT_W=4 build, 17 frames) → reads 0x1 after 17th frame.
